dense_bias_argmax_ctrl: RTL and testbench

- Sequences the final dense layer of the MNIST CNN.
- Accepts the 10 per-neuron accumulator sums from the MAC datapath, in neuron order, over a valid/ready stream.
- Walks the bias LUT address, adds each bias with saturation, and streams out the biased logits.
- Tracks the running argmax and reports the predicted digit class once all 10 neurons are done.

---
 rtl/dense_pkg.sv | 16 +
 rtl/sat_add_s.sv | 23 ++
 rtl/dense_bias_argmax_ctrl.sv | 138 +++++++++++++
 tb/tb_dense_bias_argmax_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared constants for the dense output layer: word sizes, FSM encoding and
// saturation limits.
package dense_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int NUM_CLASSES = 10;
  localparam int ADR_SIZE    = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WORD_SIZE-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [WORD_SIZE-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/sat_add_s.sv
// Combinational signed saturating adder; also reused by the conv bias stage.
module sat_add_s #(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  output logic [WORD_SIZE-1:0] sum_o
);

  logic [WORD_SIZE:0] wide;

  assign wide = {a_i[WORD_SIZE-1], a_i} + {b_i[WORD_SIZE-1], b_i};

  // Overflow when the extra sign bit disagrees with the result sign bit.
  always_comb begin
    sum_o = wide[WORD_SIZE-1:0];
    if (wide[WORD_SIZE] != wide[WORD_SIZE-1]) begin
      sum_o = wide[WORD_SIZE] ? {1'b1, {(WORD_SIZE-1){1'b0}}}
                              : {1'b0, {(WORD_SIZE-1){1'b1}}};
    end
  end

endmodule

// File: rtl/dense_bias_argmax_ctrl.sv
// Final dense layer sequencer: adds per-neuron bias with saturation, streams
// the biased logits and reports the argmax class at the end of each pass.
module dense_bias_argmax_ctrl
  import dense_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int NUM_CLASSES = 10,
  parameter int ADR_SIZE    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  input  logic                 acc_valid,
  output logic                 acc_ready,
  input  logic [WORD_SIZE-1:0] acc_data,
  output logic [ADR_SIZE-1:0]  bias_adr,
  input  logic [WORD_SIZE-1:0] bias_data,
  output logic                 logit_valid,
  output logic [ADR_SIZE-1:0]  logit_idx,
  output logic [WORD_SIZE-1:0] logit_data,
  output logic                 done,
  output logic [ADR_SIZE-1:0]  class_out,
  output logic [WORD_SIZE-1:0] class_max
);

  logic [1:0]           state_q, state_d;
  logic [ADR_SIZE-1:0]  count_q, count_d;
  logic [ADR_SIZE-1:0]  arg_q, arg_d;
  logic [WORD_SIZE-1:0] max_q, max_d;
  logic                 max_valid_q, max_valid_d;
  logic                 logit_valid_q, logit_valid_d;
  logic [ADR_SIZE-1:0]  logit_idx_q, logit_idx_d;
  logic [WORD_SIZE-1:0] logit_data_q, logit_data_d;
  logic [ADR_SIZE-1:0]  class_out_q, class_out_d;
  logic [WORD_SIZE-1:0] class_max_q, class_max_d;

  logic                 accept;
  logic                 is_last;
  logic                 take_max;
  logic [WORD_SIZE-1:0] sum;

  sat_add_s #(
    .WORD_SIZE(WORD_SIZE)
  ) u_sat_add (
    .a_i  (acc_data),
    .b_i  (bias_data),
    .sum_o(sum)
  );

  assign acc_ready   = (state_q == RUN);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign bias_adr    = count_q;
  assign logit_valid = logit_valid_q;
  assign logit_idx   = logit_idx_q;
  assign logit_data  = logit_data_q;
  assign class_out   = class_out_q;
  assign class_max   = class_max_q;

  assign accept   = acc_valid && acc_ready;
  assign is_last  = (count_q == ADR_SIZE'(NUM_CLASSES - 1));
  // Strict compare so ties keep the lower neuron index.
  assign take_max = !max_valid_q || ($signed(sum) > $signed(max_q));

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    arg_d         = arg_q;
    max_d         = max_q;
    max_valid_d   = max_valid_q;
    logit_valid_d = 1'b0;
    logit_idx_d   = logit_idx_q;
    logit_data_d  = logit_data_q;
    class_out_d   = class_out_q;
    class_max_d   = class_max_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          count_d     = '0;
          max_valid_d = 1'b0;
          class_out_d = '0;
          class_max_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          logit_valid_d = 1'b1;
          logit_idx_d   = count_q;
          logit_data_d  = sum;
          count_d       = count_q + 1'b1;
          if (take_max) begin
            max_d       = sum;
            arg_d       = count_q;
            max_valid_d = 1'b1;
          end
          // Publish the result now so it is visible alongside done.
          if (is_last) begin
            state_d     = DONE;
            class_out_d = take_max ? count_q : arg_q;
            class_max_d = take_max ? sum : max_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      arg_q         <= '0;
      max_q         <= '0;
      max_valid_q   <= 1'b0;
      logit_valid_q <= 1'b0;
      logit_idx_q   <= '0;
      logit_data_q  <= '0;
      class_out_q   <= '0;
      class_max_q   <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      arg_q         <= arg_d;
      max_q         <= max_d;
      max_valid_q   <= max_valid_d;
      logit_valid_q <= logit_valid_d;
      logit_idx_q   <= logit_idx_d;
      logit_data_q  <= logit_data_d;
      class_out_q   <= class_out_d;
      class_max_q   <= class_max_d;
    end
  end

endmodule

// File: tb/tb_dense_bias_argmax_ctrl.sv
// Directed self-checking bench for dense_bias_argmax_ctrl.
module tb_dense_bias_argmax_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        acc_valid = 1'b0;
  logic        acc_ready;
  logic [31:0] acc_data = '0;
  logic [3:0]  bias_adr;
  logic [31:0] bias_data;
  logic        logit_valid;
  logic [3:0]  logit_idx;
  logic [31:0] logit_data;
  logic        done;
  logic [3:0]  class_out;
  logic [31:0] class_max;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] acc_vec[10];
  logic [31:0] bias_mem[16];
  logic [31:0] exp_log[10];

  logic [31:0] got_data[16];
  logic [3:0]  got_idx[16];
  int          log_t[16];
  int          acc_t[10];
  int          n_log, n_done, done_t;
  logic [3:0]  done_cls;
  logic [31:0] done_max;
  logic [3:0]  cls_at_start;

  always #5 clk = ~clk;

  assign bias_data = bias_mem[bias_adr];

  dense_bias_argmax_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data),
    .bias_adr   (bias_adr),
    .bias_data  (bias_data),
    .logit_valid(logit_valid),
    .logit_idx  (logit_idx),
    .logit_data (logit_data),
    .done       (done),
    .class_out  (class_out),
    .class_max  (class_max)
  );

  function automatic logic [113:0] all_outs();
    return {busy, acc_ready, bias_adr, logit_valid, logit_idx, logit_data,
            done, class_out, class_max};
  endfunction

  // Runs one pass starting at a negedge; returns at the negedge after DONE.
  task automatic run_pass(input int gap_pct, input bit extra_starts);
    int k = 0;
    int t = 0;
    n_log = 0;
    n_done = 0;
    done_t = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cls_at_start = class_out;
    while ((k < 10 || n_done == 0) && t < 600) begin
      if (logit_valid && n_log < 16) begin
        got_data[n_log] = logit_data;
        got_idx[n_log]  = logit_idx;
        log_t[n_log]    = t;
        n_log++;
      end
      if (done) begin
        n_done++;
        done_t   = t;
        done_cls = class_out;
        done_max = class_max;
      end
      acc_valid = (k < 10) && ($urandom_range(0, 99) >= gap_pct);
      acc_data  = (k < 10) ? acc_vec[k] : 32'h0;
      start     = extra_starts && (done || ($urandom_range(0, 3) == 0));
      if (acc_valid && acc_ready) begin
        acc_t[k] = t;
        k++;
      end
      @(negedge clk);
      t++;
    end
    acc_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_pass_logits(input string name);
    tests_run++;
    if (n_log !== 10) begin
      tests_failed++;
      $display("FAIL %s logit_count got %0d want 10", name, n_log);
    end
    for (int k = 0; k < 10 && k < n_log; k++) begin
      tests_run++;
      if (got_data[k] !== exp_log[k] || got_idx[k] !== 4'(k) || log_t[k] !== acc_t[k] + 1) begin
        tests_failed++;
        $display("FAIL %s logit[%0d] got data=%h idx=%0d lat=%0d want data=%h idx=%0d lat=1",
                 name, k, got_data[k], got_idx[k], log_t[k] - acc_t[k], exp_log[k], k);
      end
    end
  endtask

  task automatic check_result(input string name, input logic [3:0] cls, input logic [31:0] mx);
    tests_run++;
    if (n_done !== 1 || done_t !== acc_t[9] + 1) begin
      tests_failed++;
      $display("FAIL %s done got count=%0d at=%0d want count=1 at=%0d", name, n_done, done_t, acc_t[9] + 1);
    end
    tests_run++;
    if (done_cls !== cls || done_max !== mx || class_out !== cls || class_max !== mx) begin
      tests_failed++;
      $display("FAIL %s class got %0d/%h want %0d/%h", name, done_cls, done_max, cls, mx);
    end
    tests_run++;
    if (busy !== 1'b0 || acc_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s idle_after got busy=%b ready=%b want 0/0", name, busy, acc_ready);
    end
  endtask

  task automatic load_ascending();
    for (int k = 0; k < 16; k++) bias_mem[k] = 32'h0;
    for (int k = 0; k < 10; k++) begin
      acc_vec[k] = 32'(k * 100);
      exp_log[k] = 32'(k * 100);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (all_outs() !== '0) begin
      tests_failed++;
      $display("FAIL reset_initial got %h want 0", all_outs());
    end
    rst = 1'b0;
    @(negedge clk);
    load_ascending();
    run_pass(0, 1'b0);
    check_result("reset_prepass", 4'd9, 32'd900);
    // Reset in IDLE with a held result.
    rst = 1'b1;
    #1;
    tests_run++;
    if (all_outs() !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle got %h want 0", all_outs());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      acc_data = acc_vec[k];
      @(negedge clk);
    end
    acc_valid = 1'b0;
    tests_run++;
    if (bias_adr !== 4'd4 || logit_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_prerun got adr=%0d lv=%b want 4/1", bias_adr, logit_valid);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (all_outs() !== '0) begin
      tests_failed++;
      $display("FAIL reset_run got %h want 0", all_outs());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_nodone got done=%b busy=%b want 0/0", done, busy);
      end
    end
    run_pass(0, 1'b0);
    check_pass_logits("reset_pass");
    check_result("reset_pass", 4'd9, 32'd900);
  endtask

  task automatic test_ascending();
    load_ascending();
    run_pass(0, 1'b0);
    check_pass_logits("ascending");
    check_result("ascending", 4'd9, 32'd900);
  endtask

  task automatic test_bias_decides();
    for (int k = 0; k < 16; k++) bias_mem[k] = 32'h0;
    bias_mem[3] = 32'h0000_0500;
    for (int k = 0; k < 10; k++) begin
      acc_vec[k] = 32'h0000_1000;
      exp_log[k] = (k == 3) ? 32'h0000_1500 : 32'h0000_1000;
    end
    run_pass(0, 1'b0);
    check_pass_logits("bias_decides");
    check_result("bias_decides", 4'd3, 32'h0000_1500);
    bias_mem[3] = 32'h0;
    for (int k = 0; k < 10; k++) begin
      acc_vec[k] = 32'hFFFF_FFFB;
      exp_log[k] = 32'hFFFF_FFFB;
    end
    run_pass(0, 1'b0);
    check_pass_logits("tie_negative");
    check_result("tie_negative", 4'd0, 32'hFFFF_FFFB);
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 16; k++) bias_mem[k] = 32'h0;
    for (int k = 0; k < 10; k++) begin
      acc_vec[k] = 32'h0;
      exp_log[k] = 32'h0;
    end
    acc_vec[2] = 32'h7FFF_FFF0; bias_mem[2] = 32'h0000_0100; exp_log[2] = 32'h7FFF_FFFF;
    acc_vec[5] = 32'h8000_0010; bias_mem[5] = 32'hFFFF_FF00; exp_log[5] = 32'h8000_0000;
    acc_vec[8] = 32'h7FFF_FF00; bias_mem[8] = 32'h0000_00FF; exp_log[8] = 32'h7FFF_FFFF;
    run_pass(0, 1'b0);
    check_pass_logits("saturation");
    check_result("saturation", 4'd2, 32'h7FFF_FFFF);
  endtask

  task automatic test_gaps();
    load_ascending();
    run_pass(70, 1'b1);
    check_pass_logits("gaps");
    check_result("gaps", 4'd9, 32'd900);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL gaps_quiet got done=%b busy=%b want 0/0", done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) bias_mem[k] = 32'h0;
    bias_mem[3] = 32'h0000_0500;
    for (int k = 0; k < 10; k++) begin
      acc_vec[k] = 32'h0000_1000;
      exp_log[k] = (k == 3) ? 32'h0000_1500 : 32'h0000_1000;
    end
    run_pass(0, 1'b0);
    check_result("b2b_first", 4'd3, 32'h0000_1500);
    load_ascending();
    bias_mem[6] = 32'd1000;
    exp_log[6]  = 32'd1600;
    run_pass(0, 1'b0);
    tests_run++;
    if (cls_at_start !== 4'd0) begin
      tests_failed++;
      $display("FAIL b2b_clear got %0d want 0", cls_at_start);
    end
    check_pass_logits("b2b_second");
    check_result("b2b_second", 4'd6, 32'd1600);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) bias_mem[k] = 32'h0;
    test_reset();
    test_ascending();
    test_bias_decides();
    test_saturation();
    test_gaps();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
